uart_port: RTL and testbench

- Peripheral that executes the core's UART instructions.
- Funct uart_tx (0x39) hands it a byte to serialise on uart_txd.
- Funct uart_rx (0x3D) reads the received byte, which returns through the MemtoReg=2'b11 write-back path.
- Serialises/deserialises 8N1 frames on the pins and stalls the core while an instruction cannot complete.

---
 rtl/uart_port.sv | 179 +++++++++++++++++
 tb/tb_uart_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_port.sv
// UART peripheral for the core's uart_tx/uart_rx instructions: 8N1 serialiser,
// synchronised deserialiser with a single-entry receive buffer, and core stall logic.
module uart_port #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  input  logic        rx_req,
  output logic [31:0] rx_data,
  output logic        stall,
  output logic        tx_busy,
  output logic        rx_valid,
  output logic        rx_frame_err,
  output logic        rx_overrun,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;
  logic             tx_busy_q, tx_busy_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_buf_q, rx_buf_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             sync1_q, sync2_q;
  logic             rxs, rd;

  assign rxs = sync2_q;
  assign rd  = rx_req & rx_valid_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: if (tx_req) begin
        tx_sh_d    = tx_data;
        tx_busy_d  = 1'b1;
        txd_d      = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        txd_d      = tx_sh_q[0];
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      TX_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_idx_q == 3'd7) begin
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          // txd takes the next bit as the shifter moves, keeping the pin registered
          tx_idx_d = tx_idx_q + 3'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          txd_d    = tx_sh_q[1];
        end
      end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      TX_STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_busy_d  = 1'b0;
        tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    if (rd) rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rxs) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rxs ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rxs, rx_sh_q[7:1]};
        rx_idx_d = rx_idx_q + 3'd1;
        if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      RX_STOP: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        // a read on the completion edge frees the slot, so it is not an overrun
        if (rxs) begin
          rx_buf_d   = rx_sh_q;
          rx_valid_d = 1'b1;
          ovr_d      = rx_valid_q & ~rd;
        end else begin
          ferr_d = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      tx_busy_q  <= tx_busy_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      sync1_q    <= uart_rxd;
      sync2_q    <= sync1_q;
    end
  end

  assign uart_txd     = txd_q;
  assign tx_busy      = tx_busy_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_data      = rx_valid_q ? {24'h0, rx_buf_q} : 32'h0;
  assign stall        = (tx_req & tx_busy_q) | (rx_req & ~rx_valid_q);

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port with CLKS_PER_BIT=4: TX framing, back-to-back stall,
// RX receive/read, read-before-data stall, glitch, framing error, overrun and reset.
module tb_uart_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        rx_req = 1'b0;
  logic [31:0] rx_data;
  logic        stall, tx_busy, rx_valid, rx_frame_err, rx_overrun, uart_txd;
  logic        uart_rxd = 1'b1;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned err_seen = 0;
  int unsigned ovr_seen = 0;
  int unsigned base_e, base_o;

  uart_port #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_data(tx_data),
    .rx_req(rx_req), .rx_data(rx_data), .stall(stall), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 clk = ~clk;

  // count high samples of the pulse outputs; a one-cycle pulse counts once
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) err_seen++;
    if (rx_overrun === 1'b1) ovr_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // called one tick after the first negedge following the accept edge
  task automatic tx_frame(input logic [7:0] d, input logic exp_stall);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk("tx_bit", 32'(uart_txd), 32'(fr[i/4]));
      chk("tx_busy", 32'(tx_busy), 32'd1);
      chk("tx_stall", 32'(stall), 32'(exp_stall));
      step();
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input logic chk_stall);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      uart_rxd = fr[b];
      for (int c = 0; c < 4; c++) begin
        #1;
        if (chk_stall) chk("rx_wait_stall", 32'(stall), 32'd1);
        if (c < 3) @(negedge clk);
      end
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input logic chk_stall);
    for (int i = 0; i < 15; i++) begin
      if (rx_valid === 1'b1) break;
      if (chk_stall) chk("rx_wait_stall", 32'(stall), 32'd1);
      step();
    end
    chk("rx_valid_timeout", 32'(rx_valid), 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rxdata", rx_data, 32'h0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single frame 0x55
    tx_req = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    tx_req = 1'b0;
    #1;
    tx_frame(8'h55, 1'b0);
    chk("t1_busy_end", 32'(tx_busy), 32'd0);
    chk("t1_txd_end", 32'(uart_txd), 32'd1);

    // 2: held request stalls, then accepted after exactly one idle cycle
    @(negedge clk);
    tx_req = 1'b1; tx_data = 8'h01;
    @(negedge clk);
    tx_data = 8'hFF;
    #1;
    tx_frame(8'h01, 1'b1);
    chk("t2_gap_busy", 32'(tx_busy), 32'd0);
    chk("t2_gap_stall", 32'(stall), 32'd0);
    chk("t2_gap_txd", 32'(uart_txd), 32'd1);
    @(negedge clk);
    tx_req = 1'b0;
    #1;
    tx_frame(8'hFF, 1'b0);
    chk("t2_busy_end", 32'(tx_busy), 32'd0);

    // 3: receive 0xA3 then read it
    send_rx(8'hA3, 1'b1, 1'b0);
    chk("t3_not_early", 32'(rx_valid), 32'd0);
    wait_valid(1'b0);
    chk("t3_rxdata", rx_data, 32'h0000_00A3);
    rx_req = 1'b1;
    #1;
    chk("t3_rd_stall", 32'(stall), 32'd0);
    chk("t3_rd_data", rx_data, 32'h0000_00A3);
    @(negedge clk);
    rx_req = 1'b0;
    #1;
    chk("t3_valid_clr", 32'(rx_valid), 32'd0);
    chk("t3_data_clr", rx_data, 32'h0);

    // 4: read issued before data arrives
    repeat (4) @(negedge clk);
    rx_req = 1'b1;
    #1;
    chk("t4_stall0", 32'(stall), 32'd1);
    send_rx(8'h3C, 1'b1, 1'b1);
    wait_valid(1'b1);
    chk("t4_stall_drop", 32'(stall), 32'd0);
    chk("t4_rxdata", rx_data, 32'h0000_003C);
    @(negedge clk);
    rx_req = 1'b0;
    #1;
    chk("t4_valid_clr", 32'(rx_valid), 32'd0);

    // 5a: one-cycle glitch
    repeat (4) @(negedge clk);
    base_e = err_seen;
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("t5_glitch_valid", 32'(rx_valid), 32'd0);
    chk("t5_glitch_ferr", err_seen - base_e, 32'd0);

    // 5b: bad stop bit
    base_e = err_seen;
    send_rx(8'h7E, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    chk("t5_ferr_once", err_seen - base_e, 32'd1);
    chk("t5_ferr_valid", 32'(rx_valid), 32'd0);

    // 6a: overrun
    base_o = ovr_seen;
    send_rx(8'h11, 1'b1, 1'b0);
    wait_valid(1'b0);
    chk("t6_first", rx_data, 32'h0000_0011);
    repeat (4) @(negedge clk);
    send_rx(8'h22, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    chk("t6_ovr_once", ovr_seen - base_o, 32'd1);
    chk("t6_valid", 32'(rx_valid), 32'd1);
    rx_req = 1'b1;
    #1;
    chk("t6_rd_data", rx_data, 32'h0000_0022);
    @(negedge clk);
    rx_req = 1'b0;
    #1;
    chk("t6_valid_clr", 32'(rx_valid), 32'd0);

    // 6b: asynchronous reset mid-TX frame
    @(negedge clk);
    tx_req = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    tx_req = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("t6_busy_pre", 32'(tx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_txd", 32'(uart_txd), 32'd1);
    chk("t6_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
